// File: rtl/command_credit_control_pkg.sv
// Shared types and defaults for the PSL command credit/tag issue stage.
package command_credit_control_pkg;

  localparam int unsigned NUM_TAGS_DEFAULT    = 32;
  localparam int unsigned TAG_WIDTH_DEFAULT   = 8;
  localparam int unsigned CROOM_WIDTH_DEFAULT = 8;

  localparam int unsigned CODE_W = 13;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned SIZE_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } credit_state_e;

  typedef logic [TAG_WIDTH_DEFAULT-1:0] tag_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [ADDR_W-1:0] address;
    logic [SIZE_W-1:0] size;
  } cmd_payload_t;

endpackage

// File: rtl/command_credit_control_tag_allocator.sv
// Tag in-use bitmap with lowest-free allocation and in-use lookup.
module command_credit_control_tag_allocator
  import command_credit_control_pkg::*;
#(
  parameter int unsigned NUM_TAGS  = NUM_TAGS_DEFAULT,
  parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEFAULT
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 alloc_in,
  output logic [TAG_WIDTH-1:0] alloc_tag_c,
  output logic                 any_free_c,
  input  logic                 free_in,
  input  logic [TAG_WIDTH-1:0] free_tag_in,
  input  logic [TAG_WIDTH-1:0] lookup_tag_in,
  output logic                 in_use_c
);

  localparam int unsigned IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  logic [NUM_TAGS-1:0] used_q;
  logic [NUM_TAGS-1:0] used_d;
  logic [IDX_W-1:0]    lowest_idx;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    lookup_idx;

  // Lowest-numbered free tag; scanning downward lets the smallest index win.
  always_comb begin
    lowest_idx = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!used_q[i]) lowest_idx = IDX_W'(i);
    end
  end

  assign alloc_tag_c = TAG_WIDTH'(lowest_idx);
  assign any_free_c  = ~(&used_q);
  assign free_idx    = IDX_W'(free_tag_in);
  assign lookup_idx  = IDX_W'(lookup_tag_in);
  assign in_use_c    = (32'(lookup_tag_in) < NUM_TAGS) && used_q[lookup_idx];

  // Bitmap update; alloc and free never target the same tag in one cycle.
  always_comb begin
    used_d = used_q;
    if (alloc_in) used_d[lowest_idx] = 1'b1;
    if (free_in)  used_d[free_idx]   = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) used_q <= '0;
    else       used_q <= used_d;
  end

endmodule

// File: rtl/command_credit_control.sv
// PSL command issue stage: croom credit gating, tag allocation, response retirement.
module command_credit_control
  import command_credit_control_pkg::*;
#(
  parameter int unsigned NUM_TAGS    = NUM_TAGS_DEFAULT,
  parameter int unsigned TAG_WIDTH   = TAG_WIDTH_DEFAULT,
  parameter int unsigned CROOM_WIDTH = CROOM_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   enabled_in,
  input  logic [CROOM_WIDTH-1:0] croom_in,
  input  logic                   cmd_valid_in,
  output logic                   cmd_ready_out,
  input  logic [CODE_W-1:0]      cmd_code_in,
  input  logic [ADDR_W-1:0]      cmd_address_in,
  input  logic [SIZE_W-1:0]      cmd_size_in,
  output logic                   cmd_valid_out,
  output logic [TAG_WIDTH-1:0]   cmd_tag_out,
  output logic [CODE_W-1:0]      cmd_code_out,
  output logic [ADDR_W-1:0]      cmd_address_out,
  output logic [SIZE_W-1:0]      cmd_size_out,
  input  logic                   response_valid_in,
  input  logic [TAG_WIDTH-1:0]   response_tag_in,
  output logic [CROOM_WIDTH-1:0] credits_out,
  output logic [TAG_WIDTH:0]     outstanding_out,
  output logic                   tag_error_out,
  output logic                   credit_error_out,
  output logic                   drained_out
);

  localparam int unsigned OUT_W = TAG_WIDTH + 1;

  credit_state_e          state_q, state_d;
  logic [CROOM_WIDTH-1:0] credits_q, credits_d;
  logic [CROOM_WIDTH-1:0] loaded_q, loaded_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic                   tag_err_q, tag_err_d;
  logic                   credit_err_q, credit_err_d;
  logic                   drained_q, drained_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [TAG_WIDTH-1:0]   cmd_tag_q, cmd_tag_d;
  cmd_payload_t           payload_q, payload_d;

  logic                   load_c;
  logic                   load_zero_c;
  logic                   credit_over_c;
  logic                   issue_c;
  logic                   resp_hit_c;
  logic [TAG_WIDTH-1:0]   alloc_tag_c;
  logic                   any_free_c;
  logic                   in_use_c;

  command_credit_control_tag_allocator #(
    .NUM_TAGS  (NUM_TAGS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_tag_allocator (
    .clock         (clock),
    .rstn          (rstn),
    .alloc_in      (issue_c),
    .alloc_tag_c   (alloc_tag_c),
    .any_free_c    (any_free_c),
    .free_in       (resp_hit_c),
    .free_tag_in   (response_tag_in),
    .lookup_tag_in (response_tag_in),
    .in_use_c      (in_use_c)
  );

  assign cmd_ready_out = (state_q == RUN) && (credits_q != '0) && any_free_c;
  assign issue_c       = cmd_valid_in && cmd_ready_out;
  assign resp_hit_c    = response_valid_in && in_use_c;

  // Next-state logic: job start, croom load, issue, drain on job end.
  always_comb begin
    state_d     = state_q;
    drained_d   = 1'b0;
    load_c      = 1'b0;
    load_zero_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (enabled_in) state_d = LOAD;
      end
      LOAD: begin
        if (!enabled_in) begin
          state_d = IDLE;
        end else if (croom_in == '0) begin
          load_zero_c = 1'b1;
        end else begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enabled_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          drained_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit/outstanding accounting; issue and retire in the same cycle cancel out.
  always_comb begin
    credits_d     = credits_q;
    loaded_d      = loaded_q;
    outstanding_d = outstanding_q;
    credit_over_c = 1'b0;
    case ({issue_c, resp_hit_c})
      2'b10: begin
        credits_d     = credits_q - CROOM_WIDTH'(1);
        outstanding_d = outstanding_q + OUT_W'(1);
      end
      2'b01: begin
        outstanding_d = outstanding_q - OUT_W'(1);
        if (credits_q >= loaded_q) begin
          credit_over_c = 1'b1;
          credits_d     = loaded_q;
        end else begin
          credits_d = credits_q + CROOM_WIDTH'(1);
        end
      end
      default: ;
    endcase
    if (load_c) begin
      credits_d = croom_in;
      loaded_d  = croom_in;
    end
    tag_err_d    = tag_err_q || (response_valid_in && !in_use_c);
    credit_err_d = credit_err_q || load_zero_c || credit_over_c;
  end

  // Command output stage: one-cycle pulse carrying the issued payload and tag.
  always_comb begin
    cmd_valid_d = issue_c;
    cmd_tag_d   = cmd_tag_q;
    payload_d   = payload_q;
    if (issue_c) begin
      cmd_tag_d         = alloc_tag_c;
      payload_d.code    = cmd_code_in;
      payload_d.address = cmd_address_in;
      payload_d.size    = cmd_size_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      credits_q     <= '0;
      loaded_q      <= '0;
      outstanding_q <= '0;
      tag_err_q     <= 1'b0;
      credit_err_q  <= 1'b0;
      drained_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_tag_q     <= '0;
      payload_q     <= '0;
    end else begin
      state_q       <= state_d;
      credits_q     <= credits_d;
      loaded_q      <= loaded_d;
      outstanding_q <= outstanding_d;
      tag_err_q     <= tag_err_d;
      credit_err_q  <= credit_err_d;
      drained_q     <= drained_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_tag_q     <= cmd_tag_d;
      payload_q     <= payload_d;
    end
  end

  assign cmd_valid_out    = cmd_valid_q;
  assign cmd_tag_out      = cmd_tag_q;
  assign cmd_code_out     = payload_q.code;
  assign cmd_address_out  = payload_q.address;
  assign cmd_size_out     = payload_q.size;
  assign credits_out      = credits_q;
  assign outstanding_out  = outstanding_q;
  assign tag_error_out    = tag_err_q;
  assign credit_error_out = credit_err_q;
  assign drained_out      = drained_q;

endmodule

// File: tb/tb_command_credit_control.sv
// Directed bench for command_credit_control: issue, retire, errors, drain, reset.
module tb_command_credit_control;

  logic        clock;
  logic        rstn;
  logic        enabled_in;
  logic [7:0]  croom_in;
  logic        cmd_valid_in;
  logic        cmd_ready_out;
  logic [12:0] cmd_code_in;
  logic [63:0] cmd_address_in;
  logic [11:0] cmd_size_in;
  logic        cmd_valid_out;
  logic [7:0]  cmd_tag_out;
  logic [12:0] cmd_code_out;
  logic [63:0] cmd_address_out;
  logic [11:0] cmd_size_out;
  logic        response_valid_in;
  logic [7:0]  response_tag_in;
  logic [7:0]  credits_out;
  logic [8:0]  outstanding_out;
  logic        tag_error_out;
  logic        credit_error_out;
  logic        drained_out;

  int vectors;
  int miscompares;

  command_credit_control #(
    .NUM_TAGS    (32),
    .TAG_WIDTH   (8),
    .CROOM_WIDTH (8)
  ) dut (
    .clock             (clock),
    .rstn              (rstn),
    .enabled_in        (enabled_in),
    .croom_in          (croom_in),
    .cmd_valid_in      (cmd_valid_in),
    .cmd_ready_out     (cmd_ready_out),
    .cmd_code_in       (cmd_code_in),
    .cmd_address_in    (cmd_address_in),
    .cmd_size_in       (cmd_size_in),
    .cmd_valid_out     (cmd_valid_out),
    .cmd_tag_out       (cmd_tag_out),
    .cmd_code_out      (cmd_code_out),
    .cmd_address_out   (cmd_address_out),
    .cmd_size_out      (cmd_size_out),
    .response_valid_in (response_valid_in),
    .response_tag_in   (response_tag_in),
    .credits_out       (credits_out),
    .outstanding_out   (outstanding_out),
    .tag_error_out     (tag_error_out),
    .credit_error_out  (credit_error_out),
    .drained_out       (drained_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] exp_code(input int k);
    return 13'(256 + k);
  endfunction

  function automatic logic [63:0] exp_addr(input int k);
    return 64'h0000_0001_0000_0000 + 64'(k) * 64'd128;
  endfunction

  task automatic set_cmd(input int k);
    cmd_code_in    = exp_code(k);
    cmd_address_in = exp_addr(k);
    cmd_size_in    = 12'(64 + k);
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_ready"}, 64'(cmd_ready_out), 64'd0);
    check_vec({tag, "_valid"}, 64'(cmd_valid_out), 64'd0);
    check_vec({tag, "_tag"}, 64'(cmd_tag_out), 64'd0);
    check_vec({tag, "_code"}, 64'(cmd_code_out), 64'd0);
    check_vec({tag, "_addr"}, cmd_address_out, 64'd0);
    check_vec({tag, "_credits"}, 64'(credits_out), 64'd0);
    check_vec({tag, "_outst"}, 64'(outstanding_out), 64'd0);
    check_vec({tag, "_tagerr"}, 64'(tag_error_out), 64'd0);
    check_vec({tag, "_crerr"}, 64'(credit_error_out), 64'd0);
    check_vec({tag, "_drained"}, 64'(drained_out), 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    enabled_in = 1'b0;
    croom_in = 8'd0;
    cmd_valid_in = 1'b0;
    response_valid_in = 1'b0;
    response_tag_in = 8'd0;
    set_cmd(0);
    repeat (2) step();
    check_all_zero("reset");
    rstn = 1'b1;

    // Test 1: croom 4, six back-to-back commands; only four issue.
    enabled_in = 1'b1;
    croom_in = 8'd4;
    step();
    step();
    check_vec("t1_loaded_credits", 64'(credits_out), 64'd4);
    cmd_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(i);
      check_vec($sformatf("t1_ready_%0d", i), 64'(cmd_ready_out), 64'd1);
      step();
      check_vec($sformatf("t1_valid_%0d", i), 64'(cmd_valid_out), 64'd1);
      check_vec($sformatf("t1_tag_%0d", i), 64'(cmd_tag_out), 64'(i));
      check_vec($sformatf("t1_code_%0d", i), 64'(cmd_code_out), 64'(exp_code(i)));
      check_vec($sformatf("t1_addr_%0d", i), cmd_address_out, exp_addr(i));
    end
    set_cmd(4);
    check_vec("t1_credits", 64'(credits_out), 64'd0);
    check_vec("t1_outst", 64'(outstanding_out), 64'd4);
    check_vec("t1_ready_low", 64'(cmd_ready_out), 64'd0);
    step();
    check_vec("t1_no_pulse", 64'(cmd_valid_out), 64'd0);
    check_vec("t1_ready_stall", 64'(cmd_ready_out), 64'd0);

    // Test 2: retire tag 2; the stalled command reuses it.
    response_valid_in = 1'b1;
    response_tag_in = 8'd2;
    step();
    response_valid_in = 1'b0;
    check_vec("t2_credits", 64'(credits_out), 64'd1);
    check_vec("t2_outst", 64'(outstanding_out), 64'd3);
    check_vec("t2_ready", 64'(cmd_ready_out), 64'd1);
    step();
    cmd_valid_in = 1'b0;
    check_vec("t2_valid", 64'(cmd_valid_out), 64'd1);
    check_vec("t2_tag", 64'(cmd_tag_out), 64'd2);
    check_vec("t2_code", 64'(cmd_code_out), 64'(exp_code(4)));
    check_vec("t2_credits_after", 64'(credits_out), 64'd0);
    check_vec("t2_outst_after", 64'(outstanding_out), 64'd4);

    // Test 4: response for a tag that is not outstanding.
    response_valid_in = 1'b1;
    response_tag_in = 8'd7;
    step();
    response_valid_in = 1'b0;
    check_vec("t4_tagerr", 64'(tag_error_out), 64'd1);
    check_vec("t4_credits", 64'(credits_out), 64'd0);
    check_vec("t4_outst", 64'(outstanding_out), 64'd4);
    step();
    check_vec("t4_tagerr_sticky", 64'(tag_error_out), 64'd1);

    // Test 3: simultaneous issue of tag 4 and retire of tag 0.
    rstn = 1'b0;
    #1;
    check_vec("t3_tagerr_clr", 64'(tag_error_out), 64'd0);
    step();
    rstn = 1'b1;
    croom_in = 8'd8;
    step();
    step();
    check_vec("t3_loaded", 64'(credits_out), 64'd8);
    cmd_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(i);
      step();
      check_vec($sformatf("t3_tag_%0d", i), 64'(cmd_tag_out), 64'(i));
    end
    set_cmd(4);
    response_valid_in = 1'b1;
    response_tag_in = 8'd0;
    step();
    response_valid_in = 1'b0;
    check_vec("t3_valid", 64'(cmd_valid_out), 64'd1);
    check_vec("t3_tag4", 64'(cmd_tag_out), 64'd4);
    check_vec("t3_credits", 64'(credits_out), 64'd4);
    check_vec("t3_outst", 64'(outstanding_out), 64'd4);
    set_cmd(5);
    step();
    cmd_valid_in = 1'b0;
    check_vec("t3_tag0_reuse", 64'(cmd_tag_out), 64'd0);
    check_vec("t3_credits2", 64'(credits_out), 64'd3);
    check_vec("t3_outst2", 64'(outstanding_out), 64'd5);

    // Out-of-range response in IDLE, zero croom load, then test 5 drain.
    rstn = 1'b0;
    enabled_in = 1'b0;
    croom_in = 8'd0;
    step();
    rstn = 1'b1;
    response_valid_in = 1'b1;
    response_tag_in = 8'd40;
    step();
    response_valid_in = 1'b0;
    check_vec("oor_tagerr", 64'(tag_error_out), 64'd1);
    check_vec("oor_outst", 64'(outstanding_out), 64'd0);
    enabled_in = 1'b1;
    step();
    step();
    check_vec("zero_croom_err", 64'(credit_error_out), 64'd1);
    check_vec("zero_croom_ready", 64'(cmd_ready_out), 64'd0);
    check_vec("zero_croom_credits", 64'(credits_out), 64'd0);
    croom_in = 8'd2;
    step();
    check_vec("t5_loaded", 64'(credits_out), 64'd2);
    check_vec("t5_ready", 64'(cmd_ready_out), 64'd1);
    cmd_valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_cmd(i);
      step();
      check_vec($sformatf("t5_tag_%0d", i), 64'(cmd_tag_out), 64'(i));
    end
    cmd_valid_in = 1'b0;
    enabled_in = 1'b0;
    check_vec("t5_outst", 64'(outstanding_out), 64'd2);
    step();
    check_vec("t5_drain_ready", 64'(cmd_ready_out), 64'd0);
    response_valid_in = 1'b1;
    response_tag_in = 8'd0;
    step();
    check_vec("t5_outst1", 64'(outstanding_out), 64'd1);
    check_vec("t5_ready_drain1", 64'(cmd_ready_out), 64'd0);
    check_vec("t5_drained_early", 64'(drained_out), 64'd0);
    response_tag_in = 8'd1;
    step();
    response_valid_in = 1'b0;
    check_vec("t5_outst0", 64'(outstanding_out), 64'd0);
    check_vec("t5_credits_back", 64'(credits_out), 64'd2);
    check_vec("t5_drained_not_yet", 64'(drained_out), 64'd0);
    check_vec("t5_ready_drain2", 64'(cmd_ready_out), 64'd0);
    step();
    check_vec("t5_drained", 64'(drained_out), 64'd1);
    step();
    check_vec("t5_drained_pulse", 64'(drained_out), 64'd0);
    croom_in = 8'd3;
    enabled_in = 1'b1;
    step();
    step();
    check_vec("t5_reload", 64'(credits_out), 64'd3);
    check_vec("t5_reload_ready", 64'(cmd_ready_out), 64'd1);

    // Test 6: asynchronous reset with three tags outstanding.
    cmd_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(i + 10);
      step();
      check_vec($sformatf("t6_tag_%0d", i), 64'(cmd_tag_out), 64'(i));
    end
    cmd_valid_in = 1'b0;
    check_vec("t6_outst", 64'(outstanding_out), 64'd3);
    rstn = 1'b0;
    #1;
    check_all_zero("t6_async");
    step();
    rstn = 1'b1;
    step();
    step();
    cmd_valid_in = 1'b1;
    set_cmd(20);
    step();
    cmd_valid_in = 1'b0;
    check_vec("t6_first_valid", 64'(cmd_valid_out), 64'd1);
    check_vec("t6_first_tag", 64'(cmd_tag_out), 64'd0);
    check_vec("t6_first_code", 64'(cmd_code_out), 64'(exp_code(20)));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/command_credit_control.md
Name: command_credit_control

Overview:
Command issue stage between the AFU command arbiter and the PSL command interface. Its input is the single arbitrated command stream from the WED, read, write and prefetch buffers. It gates issue on PSL command credits (croom), allocates a unique tag for each issued command, and returns the credit and frees the tag when the matching response arrives. It also exposes credit and outstanding counts and sticky protocol errors, which feed the error and statistics paths.

Parameters:
NUM_TAGS, 32, number of tags managed, legal range 2..256; issued tags are 0..NUM_TAGS-1.
TAG_WIDTH, 8, width of the tag field, matching the PSL ctag.
CROOM_WIDTH, 8, width of the croom and credit counters.

Ports:
clock  in  1  core clock
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  job running; a rising edge starts credit load
croom_in  in  CROOM_WIDTH  PSL command room, valid while enabled_in=1
cmd_valid_in  in  1  upstream command valid
cmd_ready_out  out  1  upstream may advance; the transfer occurs when valid&ready
cmd_code_in  in  13  PSL command opcode
cmd_address_in  in  64  effective address
cmd_size_in  in  12  transfer size in bytes
cmd_valid_out  out  1  command valid toward PSL
cmd_tag_out  out  TAG_WIDTH  allocated tag
cmd_code_out  out  13  registered opcode
cmd_address_out  out  64  registered address
cmd_size_out  out  12  registered size
response_valid_in  in  1  PSL response valid
response_tag_in  in  TAG_WIDTH  response tag
credits_out  out  CROOM_WIDTH  credits currently available
outstanding_out  out  TAG_WIDTH+1  tags currently in use
tag_error_out  out  1  sticky: a response arrived for a tag not in use
credit_error_out  out  1  sticky: a credit return would exceed the loaded croom
drained_out  out  1  pulses for one cycle when DRAIN completes

Behaviour:
- Reset (asynchronous, rstn=0): all outputs 0; state=IDLE; tag bitmap all free; credits=0; loaded_croom=0.
- States:
  - IDLE: waits for enabled_in=1, then goes to LOAD.
  - LOAD: samples croom_in into credits and loaded_croom in one cycle, then goes to RUN. If croom_in=0, sets credit_error_out and stays in LOAD.
  - RUN: issues commands. When enabled_in falls, goes to DRAIN.
  - DRAIN: cmd_ready_out=0; waits for outstanding_out=0, then pulses drained_out for one cycle and goes to IDLE.
- cmd_ready_out is combinational and is 1 only when all of these hold: state=RUN, credits>0, at least one tag free.
- Issue: on cmd_valid_in & cmd_ready_out, the command is registered to the outputs with 1-cycle latency. cmd_valid_out is a single-cycle pulse per command. The tag is the lowest-numbered free tag. The tag bit is marked used, credits is decremented and outstanding is incremented, all in the issue cycle.
- Response with response_tag_in in use: the tag is freed, credits is incremented and outstanding is decremented. The freed tag is allocatable from the next cycle.
- Response with a tag not in use, or with tag >= NUM_TAGS: sets tag_error_out; no counter change.
- Response whose credit return would make credits > loaded_croom: sets credit_error_out; credits saturates at loaded_croom.
- Simultaneous issue and valid response in the same cycle: credits and outstanding stay unchanged net. The tag being issued is free and the tag being responded to is in use, so the two never collide.
- Responses are accepted in every state, including IDLE after an abort.
- Sticky errors clear only on rstn.
- enabled_in falling mid-issue: an issue already accepted still produces cmd_valid_out on the next cycle.
- rstn asserted mid-operation: all in-flight state is discarded immediately.

Decomposition:
- Shared package (AFU_PKG): state enum CreditState {IDLE, LOAD, RUN, DRAIN}; NUM_TAGS default constant; tag type.
- One sub-module, tag_allocator: in-use bitmap, lowest-free priority encoder, any_free flag, alloc/free ports, in_use lookup. The counters and FSM stay in the parent.

Test Plan:
1. Reset, enabled_in=1, croom_in=4, 6 back-to-back cmd_valid_in:
   - tags 0,1,2,3 are issued, each one cycle after its handshake;
   - cmd_ready_out drops after the 4th; credits_out=0, outstanding_out=4.
2. From test 1, response for tag 2:
   - next cycle credits_out=1; the pending 5th command issues with tag 2.
3. Same-cycle issue (tag 4 free) and response for tag 0:
   - credits_out unchanged, outstanding_out unchanged; tag 0 is free the next cycle.
4. Response tag 7 with no tag 7 outstanding:
   - tag_error_out=1 and remains 1; counters unchanged.
5. croom_in=2, issue 2, drop enabled_in, return both responses:
   - state passes through DRAIN; cmd_ready_out=0 throughout;
   - drained_out pulses one cycle after the last response; a re-enable reloads croom.
6. Assert rstn=0 with 3 tags outstanding:
   - all outputs are 0 in the same cycle; after release, the first issue gets tag 0.
